// File: rtl/mig_ui_responder.sv
// mig_ui_responder: block-RAM backed responder for the MIG 7-series app_* user interface.
// Stands in for the DDR controller so the adapter above it can run without DDR pins.
// Optional macro MIG_UI_RAND_STALL_EN adds LFSR-driven pseudo-random backpressure
// on app_rdy and app_wdf_rdy; without it only calibration, WAIT_WDATA and refresh stall.
module mig_ui_responder #(
    parameter int DATA_WIDTH     = 128,
    parameter int ADDR_WIDTH     = 27,
    parameter int MEM_DEPTH_LOG2 = 10,
    parameter int CALIB_CYCLES   = 64,
    parameter int RD_LATENCY     = 4,
    parameter int REFRESH_PERIOD = 512,
    parameter int REFRESH_STALL  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   app_addr,
    input  logic [2:0]              app_cmd,
    input  logic                    app_en,
    output logic                    app_rdy,
    input  logic [DATA_WIDTH-1:0]   app_wdf_data,
    input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                    app_wdf_wren,
    input  logic                    app_wdf_end,
    output logic                    app_wdf_rdy,
    output logic [DATA_WIDTH-1:0]   app_rd_data,
    output logic                    app_rd_data_valid,
    output logic                    app_rd_data_end,
    output logic                    init_calib_complete
);
    localparam int MW = DATA_WIDTH / 8;
    localparam int CW = $clog2(CALIB_CYCLES + 1);
    localparam int RW = $clog2(REFRESH_PERIOD);
    localparam int SW = $clog2(REFRESH_STALL);
    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {RUN, WAIT_WDATA, REFRESH} state_t;

    state_t                    state, state_n;
    logic [DATA_WIDTH-1:0]     mem [1 << MEM_DEPTH_LOG2];
    logic [CW-1:0]             cal_cnt;
    logic                      calib;
    logic [RW-1:0]             ref_cnt;
    logic                      ref_pend, ref_wrap;
    logic [SW-1:0]             stall_cnt;
    logic                      stall_cmd, stall_wdf, rd_credit_avail;
    logic                      cmd_acc, rd_acc, wr_acc, wr_commit, wd_avail, push;
    logic [1:0]                f_cnt;
    logic                      f_wp, f_rp;
    logic [DATA_WIDTH-1:0]     f_data [2];
    logic [MW-1:0]             f_mask [2];
    logic [DATA_WIDTH-1:0]     head_data;
    logic [MW-1:0]             head_mask;
    logic [MEM_DEPTH_LOG2-1:0] cmd_idx, wait_idx, wr_idx, rd_idx;
    logic [RD_LATENCY-1:0]     vld;
    logic [DATA_WIDTH-1:0]     rd_pipe [1:RD_LATENCY-1];
    logic                      unused;

    // The read pipeline never blocks; this hook exists for a future stall feature.
    assign rd_credit_avail     = 1'b1;
    assign cmd_idx             = app_addr[MEM_DEPTH_LOG2+2:3];
    assign unused              = ^{app_wdf_end, app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], app_addr[2:0]};
    assign init_calib_complete = calib;
    assign ref_wrap            = ref_cnt == RW'(REFRESH_PERIOD - 1);
    assign app_rd_data         = rd_pipe[RD_LATENCY-1];
    assign app_rd_data_valid   = vld[RD_LATENCY-1];
    assign app_rd_data_end     = vld[RD_LATENCY-1];

`ifdef MIG_UI_RAND_STALL_EN
    logic [15:0] lfsr;

    // Free-running x^16+x^14+x^13+x^11 LFSR supplying pseudo-random stall decisions
    always_ff @(posedge clk)
        lfsr <= rst ? 16'hACE1 : {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    assign stall_cmd = lfsr[2:0] == 3'd0;
    assign stall_wdf = lfsr[5:3] == 3'd0;
`else
    assign stall_cmd = 1'b0;
    assign stall_wdf = 1'b0;
`endif

    // Calibration delay: flag rises when the counter reaches CALIB_CYCLES, sticky until reset
    always_ff @(posedge clk)
        if (rst) begin
            cal_cnt <= '0;
            calib   <= 1'b0;
        end else if (!calib) begin
            cal_cnt <= cal_cnt + 1'b1;
            calib   <= cal_cnt == CW'(CALIB_CYCLES - 1);
        end

    // Refresh timer; a due refresh is held pending until RUN can take it
    always_ff @(posedge clk)
        if (rst) begin
            ref_cnt  <= '0;
            ref_pend <= 1'b0;
        end else if (calib) begin
            ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;
            ref_pend <= ref_wrap || (ref_pend && state != RUN);
        end

    // Counts REFRESH cycles; the RUN cycle that sees the pending refresh is the first stall cycle
    always_ff @(posedge clk)
        stall_cnt <= (rst || state != REFRESH) ? '0 : stall_cnt + 1'b1;

    // Command FSM state register
    always_ff @(posedge clk)
        state <= rst ? RUN : state_n;

    // Command FSM next state
    always_comb
        state_n = (state == RUN && ref_pend)                          ? REFRESH    :
                  (state == RUN && wr_acc && !wd_avail)               ? WAIT_WDATA :
                  (state == WAIT_WDATA && wd_avail)                   ? RUN        :
                  (state == REFRESH && stall_cnt == SW'(REFRESH_STALL - 2)) ? RUN  : state;

    // Command FSM outputs: accept decode and write commit selection
    always_comb begin
        app_rdy   = state == RUN && calib && !ref_pend && rd_credit_avail && !stall_cmd;
        cmd_acc   = app_en && app_rdy;
        rd_acc    = cmd_acc && app_cmd == CMD_RD;
        wr_acc    = cmd_acc && app_cmd == CMD_WR;
        wr_commit = (wr_acc || state == WAIT_WDATA) && wd_avail;
        wr_idx    = state == WAIT_WDATA ? wait_idx : cmd_idx;
    end

    // Write-data FIFO head, with bypass so a beat pushed this cycle can commit at once
    always_comb begin
        app_wdf_rdy = calib && !f_cnt[1] && !stall_wdf;
        push        = app_wdf_wren && app_wdf_rdy;
        wd_avail    = f_cnt != 2'd0 || push;
        head_data   = f_cnt != 2'd0 ? f_data[f_rp] : app_wdf_data;
        head_mask   = f_cnt != 2'd0 ? f_mask[f_rp] : app_wdf_mask;
    end

    // Write-data FIFO occupancy and pointers
    always_ff @(posedge clk)
        if (rst) begin
            f_cnt <= 2'd0;
            f_wp  <= 1'b0;
            f_rp  <= 1'b0;
        end else begin
            f_cnt <= f_cnt + {1'b0, push} - {1'b0, wr_commit};
            f_wp  <= f_wp ^ push;
            f_rp  <= f_rp ^ wr_commit;
        end

    // Write-data FIFO storage
    always_ff @(posedge clk)
        if (push) begin
            f_data[f_wp] <= app_wdf_data;
            f_mask[f_wp] <= app_wdf_mask;
        end

    // Remember the address of a write that is still waiting for its data
    always_ff @(posedge clk)
        if (wr_acc && !wd_avail)
            wait_idx <= cmd_idx;

    // Block RAM: byte-masked write and registered read address; contents survive reset
    always_ff @(posedge clk) begin
        rd_idx <= cmd_idx;
        if (wr_commit)
            for (int b = 0; b < MW; b++)
                if (!head_mask[b])
                    mem[wr_idx][8*b +: 8] <= head_data[8*b +: 8];
    end

    // Read pipeline: RAM read one stage after accept, then shift to the output stage
    always_ff @(posedge clk)
        if (rst) begin
            vld <= '0;
            for (int i = 1; i < RD_LATENCY; i++)
                rd_pipe[i] <= '0;
        end else begin
            vld        <= {vld[RD_LATENCY-2:0], rd_acc};
            rd_pipe[1] <= mem[rd_idx];
            for (int i = 2; i < RD_LATENCY; i++)
                rd_pipe[i] <= rd_pipe[i-1];
        end
endmodule

// File: tb/tb_mig_ui_responder.sv
// tb_mig_ui_responder: directed self-checking bench for mig_ui_responder (default build).
module tb_mig_ui_responder;
    localparam logic [2:0]   CMD_WR = 3'b000;
    localparam logic [2:0]   CMD_RD = 3'b001;
    localparam logic [127:0] D1 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] D2 = 128'hDEADBEEFCAFEF00D1122334455667788;
    localparam logic [127:0] P  = 128'h55555555555555555555555555555555;
    localparam logic [127:0] DA = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam logic [127:0] DB = 128'hB0B1B2B3B4B5B6B7B8B9BABBBCBDBEBF;
    localparam logic [127:0] DM = 128'h0000000000000000FFFFFFFFFFFFFFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [26:0]  app_addr = '0;
    logic [2:0]   app_cmd = '0;
    logic         app_en = 1'b0;
    logic         app_wdf_wren = 1'b0;
    logic         app_wdf_end = 1'b0;
    logic [127:0] app_wdf_data = '0;
    logic [15:0]  app_wdf_mask = '0;
    logic         app_rdy, app_wdf_rdy, app_rd_data_valid, app_rd_data_end, init_calib_complete;
    logic [127:0] app_rd_data;

    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [127:0] vq_d[$];
    int           vq_c[$];
    logic         vq_e[$];
    int           ac, vc, r, lows;
    int           st[$];
    logic [127:0] d;
    logic         e, prev;
    logic [26:0]  addrs [6] = '{27'h040, 27'h080, 27'h100, 27'h040, 27'h080, 27'h100};

    mig_ui_responder dut (
        .clk                 (clk),
        .rst                 (rst),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .app_rd_data_end     (app_rd_data_end),
        .init_calib_complete (init_calib_complete)
    );

    always #5 clk = ~clk;

    // Cycle index: 0 is the first cycle after reset is released
    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

    // Capture every read return with the cycle it appeared in
    always @(negedge clk)
        if (app_rd_data_valid) begin
            vq_d.push_back(app_rd_data);
            vq_c.push_back(cyc);
            vq_e.push_back(app_rd_data_end);
        end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        app_en = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
    endtask

    // Walks cycles 0..64 after reset release; returns at the start of cycle 65
    task automatic calib_check();
        for (int k = 0; k <= 64; k++) begin
            @(negedge clk);
            chk("calib", init_calib_complete, k == 64);
            chk("calib_rdy", app_rdy, k == 64);
            chk("calib_wdf_rdy", app_wdf_rdy, k == 64);
            if (k == 0) begin
                chk("rst_valid", app_rd_data_valid, 0);
                chk("rst_end", app_rd_data_end, 0);
                chk("rst_data", app_rd_data, 0);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Presents a command and/or a data beat and holds each until it transfers
    task automatic xfer(input logic dc, input logic [2:0] c, input logic [26:0] a,
                        input logic dd, input logic [127:0] dat, input logic [15:0] m,
                        output int acyc);
        int n;
        logic ce, de;
        n = 0;
        acyc = -1;
        app_en = dc;
        app_cmd = c;
        app_addr = a;
        app_wdf_wren = dd;
        app_wdf_end = dd;
        app_wdf_data = dat;
        app_wdf_mask = m;
        while ((app_en || app_wdf_wren) && n < 100) begin
            @(negedge clk);
            ce = app_en & app_rdy;
            de = app_wdf_wren & app_wdf_rdy;
            if (ce) acyc = cyc;
            @(posedge clk);
            #1;
            if (ce) app_en = 1'b0;
            if (de) begin
                app_wdf_wren = 1'b0;
                app_wdf_end = 1'b0;
            end
            n++;
        end
        chk("xfer_stuck", app_en | app_wdf_wren, 0);
        app_en = 1'b0;
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
    endtask

    task automatic get_rd(output logic [127:0] dat, output int vcyc, output logic ve);
        int n;
        n = 0;
        while (vq_d.size() == 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rd_timeout", vq_d.size() != 0, 1);
        if (vq_d.size() != 0) begin
            dat = vq_d.pop_front();
            vcyc = vq_c.pop_front();
            ve = vq_e.pop_front();
        end else begin
            dat = 'x;
            vcyc = -1;
            ve = 1'b0;
        end
    endtask

    task automatic rd(input string tag, input logic [26:0] a, input logic [127:0] exp);
        int acyc, vcyc;
        logic [127:0] dat;
        logic ve;
        xfer(1'b1, CMD_RD, a, 1'b0, '0, '0, acyc);
        get_rd(dat, vcyc, ve);
        chk({tag, "_lat"}, vcyc - acyc, 4);
        chk({tag, "_data"}, dat, exp);
        chk({tag, "_end"}, ve, 1);
    endtask

    initial begin
        // Reset and calibration window
        do_reset();
        calib_check();

        // Write with data and command in the same cycle, then read back
        xfer(1'b1, CMD_WR, 27'h040, 1'b1, D1, 16'h0000, ac);
        rd("rd40", 27'h040, D1);

        // Write command ahead of its data, read queued behind it
        xfer(1'b1, CMD_WR, 27'h080, 1'b1, P, 16'h0000, ac);
        xfer(1'b1, CMD_WR, 27'h080, 1'b0, '0, '0, ac);
        app_en = 1'b1;
        app_cmd = CMD_RD;
        app_addr = 27'h080;
        @(negedge clk);
        chk("wait_rdy1", app_rdy, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("wait_rdy2", app_rdy, 0);
        @(posedge clk);
        #1;
        app_wdf_wren = 1'b1;
        app_wdf_end = 1'b1;
        app_wdf_data = D2;
        app_wdf_mask = 16'h0000;
        @(negedge clk);
        chk("wait_rdy3", app_rdy, 0);
        chk("wait_wdf_rdy", app_wdf_rdy, 1);
        @(posedge clk);
        #1;
        app_wdf_wren = 1'b0;
        app_wdf_end = 1'b0;
        @(negedge clk);
        chk("wait_release", app_rdy, 1);
        ac = cyc;
        @(posedge clk);
        #1;
        app_en = 1'b0;
        get_rd(d, vc, e);
        chk("raw_lat", vc - ac, 4);
        chk("raw_data", d, D2);

        // Byte masking, including a fully masked write
        xfer(1'b1, CMD_WR, 27'h100, 1'b1, {128{1'b1}}, 16'h0000, ac);
        xfer(1'b1, CMD_WR, 27'h100, 1'b1, '0, 16'h00FF, ac);
        rd("mask", 27'h100, DM);
        xfer(1'b1, CMD_WR, 27'h100, 1'b1, '0, 16'hFFFF, ac);
        rd("mask_all", 27'h100, DM);

        // Data ahead of commands: fill the FIFO, then drain it with commands
        xfer(1'b0, CMD_WR, '0, 1'b1, DA, 16'h0000, ac);
        xfer(1'b0, CMD_WR, '0, 1'b1, DB, 16'h0000, ac);
        @(negedge clk);
        chk("fifo_full", app_wdf_rdy, 0);
        @(posedge clk);
        #1;
        xfer(1'b1, CMD_WR, 27'h180, 1'b0, '0, '0, ac);
        @(negedge clk);
        chk("fifo_drain", app_wdf_rdy, 1);
        chk("no_wait", app_rdy, 1);
        @(posedge clk);
        #1;
        xfer(1'b1, CMD_WR, 27'h1C0, 1'b0, '0, '0, ac);
        rd("fifo_a", 27'h180, DA);
        rd("fifo_b", 27'h1C0, DB);

        // Back-to-back reads with reset landing on the second return
        vq_d.delete();
        vq_c.delete();
        vq_e.delete();
        app_en = 1'b1;
        app_cmd = CMD_RD;
        for (int i = 0; i < 5; i++) begin
            app_addr = addrs[i];
            @(negedge clk);
            chk("b2b_rdy", app_rdy, 1);
            if (i == 0) r = cyc;
            @(posedge clk);
            #1;
        end
        app_addr = addrs[5];
        do_reset();
        calib_check();
        chk("rst_pulses", vq_d.size(), 2);
        get_rd(d, vc, e);
        chk("b2b0_lat", vc - r, 4);
        chk("b2b0_data", d, D1);
        get_rd(d, vc, e);
        chk("b2b1_lat", vc - r, 5);
        chk("b2b1_data", d, D2);
        rd("keep40", 27'h040, D1);
        rd("keep80", 27'h080, D2);
        rd("keep100", 27'h100, DM);

        // Continuous reads across two refresh windows
        do_reset();
        vq_d.delete();
        vq_c.delete();
        vq_e.delete();
        app_en = 1'b1;
        app_cmd = CMD_RD;
        app_addr = 27'h040;
        lows = 0;
        prev = 1'b1;
        for (int k = 0; k < 1264; k++) begin
            @(negedge clk);
            if (k >= 64) begin
                if (!app_rdy) begin
                    lows++;
                    if (prev) st.push_back(cyc);
                end
                prev = app_rdy;
            end
            @(posedge clk);
            #1;
        end
        app_en = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("ref_lows", lows, 16);
        chk("ref_runs", st.size(), 2);
        chk("ref_first", st.size() > 0 ? st[0] : -1, 576);
        chk("ref_second", st.size() > 1 ? st[1] : -1, 1088);
        chk("ref_reads", vq_d.size(), 1184);
        chk("ref_data", vq_d.size() > 0 ? vq_d[0] : 128'hx, D1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mig_ui_responder.md
Name: mig_ui_responder

Overview:
- Responder end of the MIG 7-series user (app_*) interface: accepts app_cmd/app_addr/app_wdf_* from an initiator and answers with app_rdy, app_wdf_rdy, app_rd_data and init_calib_complete.
- Backed by an on-chip block RAM.
- Replaces mig_7series_0 in simulation and in DDR-less FPGA builds, so the DDR adapter above it can be exercised without DDR2 pins.

Parameters:
- DATA_WIDTH, 128: app_wdf_data/app_rd_data width; mask width is DATA_WIDTH/8.
- ADDR_WIDTH, 27: app_addr width.
- MEM_DEPTH_LOG2, 10: log2 of the number of DATA_WIDTH-bit words stored.
- CALIB_CYCLES, 64: cycles after reset until init_calib_complete rises.
- RD_LATENCY, 4: cycles from read-command acceptance to app_rd_data_valid; must be >=2.
- REFRESH_PERIOD, 512: cycles between refresh stalls.
- REFRESH_STALL, 8: app_rdy low cycles per refresh.

Ports:
- clk  in  1  ui clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- app_addr  in  ADDR_WIDTH  column address; word index = app_addr[MEM_DEPTH_LOG2+2:3]; bits [2:0] and upper bits ignored.
- app_cmd  in  3  3'b000 write, 3'b001 read; other codes are accepted and ignored.
- app_en  in  1  command valid.
- app_rdy  out  1  command accept; a command transfers when app_en & app_rdy.
- app_wdf_data  in  DATA_WIDTH  write data.
- app_wdf_mask  in  DATA_WIDTH/8  bit i=1 -> byte i not written.
- app_wdf_wren  in  1  write data valid; transfers when app_wdf_wren & app_wdf_rdy.
- app_wdf_end  in  1  last beat; always equals wren (one beat per burst); its value is ignored.
- app_wdf_rdy  out  1  write-data FIFO can accept.
- app_rd_data  out  DATA_WIDTH  read data.
- app_rd_data_valid  out  1  read data valid, one pulse per read.
- app_rd_data_end  out  1  equals app_rd_data_valid.
- init_calib_complete  out  1  high once the calibration delay has expired.

Behaviour:
- Reset values: app_rdy=0, app_wdf_rdy=0, app_rd_data_valid=0, app_rd_data_end=0, app_rd_data=0, init_calib_complete=0.
- Reset clears all counters, the FIFOs and the read pipeline. RAM contents are retained.
- Reset mid-operation discards in-flight reads (no valid pulses afterwards) and pending writes. Calibration restarts.

Calibration:
- Counter runs from 0 after reset.
- init_calib_complete goes 1 on the cycle the counter reaches CALIB_CYCLES and stays 1 until rst.
- app_rdy and app_wdf_rdy stay 0 until then.

Write data FIFO:
- Depth 2, holds {data, mask}.
- app_wdf_rdy = calib & !full.
- Data may arrive before, with, or after its command; commands and data pair in order.

Command FSM, states RUN, WAIT_WDATA, REFRESH:
- RUN: app_rdy = calib & !refresh_due & rd_credit_avail.
- Accepted read: issued to the read pipeline.
- Accepted write with a FIFO entry available (including an entry pushed the same cycle): RAM write that cycle, FIFO pop.
- Accepted write without data -> WAIT_WDATA.
- WAIT_WDATA: app_rdy=0; on the first FIFO entry, commit the write and return to RUN. This preserves command order, so read-after-write returns the new data.
- REFRESH: entered from RUN when the refresh counter wraps (every REFRESH_PERIOD cycles after calib) and no write is pending. app_rdy=0 for REFRESH_STALL cycles, then RUN.
- A refresh due during WAIT_WDATA is deferred until the write commits.
- app_wdf_rdy is unaffected by REFRESH.

Read pipeline:
- Shift register of length RD_LATENCY carrying a valid bit; data is read from RAM at the stage after acceptance.
- Returns in order, exactly RD_LATENCY cycles after acceptance.
- Back-to-back reads give back-to-back valid pulses.
- rd_credit_avail is always 1 (pipeline is non-blocking); reserved for the stall feature.

Byte masking:
- Masked bytes keep their old RAM value.
- Mask 16'hFFFF commits nothing but still consumes the command and the data.

Simultaneous events:
- Command accept and FIFO push in the same cycle are both legal.
- FIFO push and pop in the same cycle keep the count.

Optional Feature:
- Macro MIG_UI_RAND_STALL_EN.
- Defined: a 16-bit LFSR (seed 16'hACE1 at reset, x^16+x^14+x^13+x^11) forces app_rdy=0 when its low 3 bits are 0, and app_wdf_rdy=0 when bits [5:3] are 0. This adds pseudo-random backpressure; all ordering rules still hold.
- Undefined: only the calibration, WAIT_WDATA and refresh stalls exist.

Test Plan:
- Reset, then idle -> init_calib_complete=0 through cycle 63 and 1 at cycle 64; app_rdy=0 before that.
- Write 128'h0123...CDEF to app_addr 27'h000_0040 with data and command in the same cycle, then read 27'h40 -> app_rd_data_valid exactly 4 cycles after read accept, data 128'h0123...CDEF.
- Write command to 27'h80 with data presented 3 cycles later, and read 27'h80 queued behind it -> app_rdy low for 3 cycles; read returns the new data.
- Write 128'hFFFF..FF to 27'h100, then write 128'h0 with mask 16'h00FF -> read gives upper 8 bytes 0x00 and lower 8 bytes 0xFF.
- Hold app_en continuously for 1200 cycles -> app_rdy drops for exactly 8 cycles every 512 cycles.
- Issue 6 back-to-back reads, then assert rst after 2 valid pulses -> no further valid pulses; calibration restarts; data written before the reset reads back unchanged.
